// File: rtl/cluster_fetch_pkg.sv
// Shared types and helpers for the cluster instruction-fetch stage.
// Lane geometry, FSM state encoding and the bundle lane-slice function.
package cluster_fetch_pkg;

  localparam int LANES    = 4;
  localparam int INSTR_W  = 32;
  localparam int PC_W     = 32;
  localparam int BUNDLE_W = LANES * INSTR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } fetch_state_t;

  function automatic logic [INSTR_W-1:0] lane_word(input logic [BUNDLE_W-1:0] bundle,
                                                   input logic [1:0]          idx);
    return bundle[idx*INSTR_W +: INSTR_W];
  endfunction

endpackage

// File: rtl/cluster_fetch_if.sv
// Request, instruction-memory and response signals of the fetch stage.
// master is the fetch unit; slave is the surrounding pipeline/memory.
interface cluster_fetch_if
  import cluster_fetch_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic                 req_valid;
  logic                 req_ready;
  logic [BUNDLE_W-1:0]  req_pc;
  logic [LANES-1:0]     req_lane_en;
  logic                 flush;
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [INSTR_W-1:0]   mem_rdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [BUNDLE_W-1:0]  rsp_instr;
  logic [LANES-1:0]     rsp_lane_valid;
  logic [LANES-1:0]     rsp_fault;
  logic [31:0]          fetch_count;

  modport master (
    input  req_valid, req_pc, req_lane_en, flush, mem_rdata, rsp_ready,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_instr,
           rsp_lane_valid, rsp_fault, fetch_count
  );

  modport slave (
    output req_valid, req_pc, req_lane_en, flush, mem_rdata, rsp_ready,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_instr,
           rsp_lane_valid, rsp_fault, fetch_count
  );
endinterface

// File: rtl/cluster_fetch_unit.sv
// Four-lane instruction fetch: walks the lanes one per cycle through a single
// read port, assembles a 128-bit bundle and hands it over with valid/ready.
module cluster_fetch_unit
  import cluster_fetch_pkg::*;
#(
  parameter int                 ADDR_W     = 10,
  parameter logic [INSTR_W-1:0] FILL_INSTR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  cluster_fetch_if.master bus
);

  fetch_state_t         state_q, state_d;
  logic [1:0]           lane_q;
  logic [BUNDLE_W-1:0]  pc_q;
  logic [LANES-1:0]     en_q;
  logic [BUNDLE_W-1:0]  instr_q;
  logic [LANES-1:0]     lane_valid_q;
  logic [LANES-1:0]     fault_q;
  logic [31:0]          fetch_count_q;
  logic                 rd_vld_p1;
  logic [1:0]           rd_lane_p1;

  logic [PC_W-1:0]      cur_pc;
  logic                 cur_en;
  logic                 cur_in_range;
  logic                 issue_rd;
  logic                 accept;
  logic                 rsp_fire;

  always_comb begin
    cur_pc       = lane_word(pc_q, lane_q);
    cur_en       = en_q[lane_q];
    cur_in_range = (cur_pc[PC_W-1:ADDR_W] == '0);
    issue_rd     = (state_q == ISSUE) && cur_en && cur_in_range;
    accept       = (state_q == IDLE) && !bus.flush && bus.req_valid;
    rsp_fire     = (state_q == RESP) && !bus.flush && bus.rsp_ready;
  end

  always_comb begin
    bus.req_ready      = (state_q == IDLE) && !bus.flush;
    bus.mem_rd_en      = issue_rd;
    bus.mem_addr       = issue_rd ? cur_pc[ADDR_W-1:0] : '0;
    bus.rsp_valid      = (state_q == RESP);
    bus.rsp_instr      = instr_q;
    bus.rsp_lane_valid = lane_valid_q;
    bus.rsp_fault      = fault_q;
    bus.fetch_count    = fetch_count_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (lane_q == 2'd3) state_d = DRAIN;
      DRAIN:   state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request latch: PCs and enables are plain data, held for the whole walk.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q <= bus.req_pc;
      en_q <= bus.req_lane_en;
    end
  end

  // Issue stage (p0) -> capture stage (p1): memory data lands one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q        <= 2'd0;
      rd_vld_p1     <= 1'b0;
      rd_lane_p1    <= 2'd0;
      instr_q       <= '0;
      lane_valid_q  <= '0;
      fault_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      rd_vld_p1  <= issue_rd && !bus.flush;
      rd_lane_p1 <= lane_q;

      if (bus.flush) begin
        lane_q <= 2'd0;
      end else if (accept) begin
        lane_q       <= 2'd0;
        instr_q      <= {LANES{FILL_INSTR}};
        lane_valid_q <= '0;
        fault_q      <= '0;
      end else if (state_q == ISSUE) begin
        lane_q <= lane_q + 2'd1;
        if (cur_en && !cur_in_range) fault_q[lane_q] <= 1'b1;
      end

      if (rd_vld_p1 && !bus.flush) begin
        instr_q[rd_lane_p1*INSTR_W +: INSTR_W] <= bus.mem_rdata;
        lane_valid_q[rd_lane_p1]               <= 1'b1;
      end

      if (rsp_fire) fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_cluster_fetch_unit.sv
// Directed bench for cluster_fetch_unit with a preloaded 1-cycle ROM model.
module tb_cluster_fetch_unit;
  import cluster_fetch_pkg::*;

  localparam int                 ADDR_W = 10;
  localparam logic [31:0]        FILL   = 32'hDEAD_BEEF;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   lat;
  int   exp_count;
  logic [3:0]        rd_log;
  logic [ADDR_W-1:0] addr_log [4];

  cluster_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  cluster_fetch_unit #(.ADDR_W(ADDR_W), .FILL_INSTR(FILL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // instr_rom_model: registered single-port read, rom[i] = 0x1000_0000 + i
  logic [31:0] rom [1 << ADDR_W];
  logic [31:0] rom_q;
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 32'h1000_0000 + i;
    rom_q = '0;
  end
  always @(posedge clk) if (bus.mem_rd_en) rom_q <= rom[bus.mem_addr];
  assign bus.mem_rdata = rom_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue_req(input logic [127:0] pc, input logic [3:0] en);
    @(negedge clk);
    bus.req_pc      = pc;
    bus.req_lane_en = en;
    bus.req_valid   = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat    = -1;
    rd_log = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        rd_log[c-1]   = bus.mem_rd_en;
        addr_log[c-1] = bus.mem_addr;
      end
      if (bus.rsp_valid) begin
        lat = c - 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    n_checks++; if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd_en got %b want 0", bus.mem_rd_en); end
    n_checks++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_instr !== '0) begin n_fail++; $display("FAIL reset_rsp_instr got %h want 0", bus.rsp_instr); end
    n_checks++; if ({bus.rsp_lane_valid, bus.rsp_fault} !== 8'h00) begin n_fail++; $display("FAIL reset_flags got %b/%b want 0000/0000", bus.rsp_lane_valid, bus.rsp_fault); end
    n_checks++; if (bus.fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_fetch_count got %0d want 0", bus.fetch_count); end
  endtask

  task automatic test_full_bundle;
    bus.rsp_ready = 1'b1;
    issue_req({32'd3, 32'd2, 32'd1, 32'd0}, 4'b1111);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL full_latency got %0d want 5", lat); end
    n_checks++; if (bus.rsp_instr !== {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000}) begin n_fail++; $display("FAIL full_instr got %h", bus.rsp_instr); end
    n_checks++; if (bus.rsp_lane_valid !== 4'b1111 || bus.rsp_fault !== 4'b0000) begin n_fail++; $display("FAIL full_flags got %b/%b want 1111/0000", bus.rsp_lane_valid, bus.rsp_fault); end
    n_checks++; if (rd_log !== 4'b1111) begin n_fail++; $display("FAIL full_reads got %b want 1111", rd_log); end
    @(negedge clk);
    exp_count++;
    n_checks++; if (bus.fetch_count !== exp_count) begin n_fail++; $display("FAIL full_count got %0d want %0d", bus.fetch_count, exp_count); end
    n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL full_return_idle got ready=%b valid=%b want 1/0", bus.req_ready, bus.rsp_valid); end
  endtask

  task automatic test_sparse_enable;
    issue_req({32'd7, 32'd6, 32'd5, 32'd4}, 4'b0101);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sparse_latency got %0d want 5", lat); end
    n_checks++; if (rd_log !== 4'b0101) begin n_fail++; $display("FAIL sparse_reads got %b want 0101", rd_log); end
    n_checks++; if (addr_log[0] !== 10'd4 || addr_log[1] !== 10'd0 || addr_log[2] !== 10'd6 || addr_log[3] !== 10'd0) begin n_fail++; $display("FAIL sparse_addrs got %0d %0d %0d %0d want 4 0 6 0", addr_log[0], addr_log[1], addr_log[2], addr_log[3]); end
    n_checks++; if (bus.rsp_instr !== {FILL, 32'h1000_0006, FILL, 32'h1000_0004}) begin n_fail++; $display("FAIL sparse_instr got %h", bus.rsp_instr); end
    n_checks++; if (bus.rsp_lane_valid !== 4'b0101 || bus.rsp_fault !== 4'b0000) begin n_fail++; $display("FAIL sparse_flags got %b/%b want 0101/0000", bus.rsp_lane_valid, bus.rsp_fault); end
    @(negedge clk);
    exp_count++;
  endtask

  task automatic test_range_fault;
    issue_req({32'h9, 32'h0000_0400, 32'h8, 32'h7}, 4'b1111);
    n_checks++; if (rd_log !== 4'b1011) begin n_fail++; $display("FAIL range_reads got %b want 1011", rd_log); end
    n_checks++; if (bus.rsp_fault !== 4'b0100 || bus.rsp_lane_valid !== 4'b1011) begin n_fail++; $display("FAIL range_flags got fault=%b valid=%b want 0100/1011", bus.rsp_fault, bus.rsp_lane_valid); end
    n_checks++; if (bus.rsp_instr !== {32'h1000_0009, FILL, 32'h1000_0008, 32'h1000_0007}) begin n_fail++; $display("FAIL range_instr got %h", bus.rsp_instr); end
    @(negedge clk);
    exp_count++;
    n_checks++; if (bus.fetch_count !== exp_count) begin n_fail++; $display("FAIL range_count got %0d want %0d", bus.fetch_count, exp_count); end
  endtask

  task automatic test_backpressure;
    logic [127:0] exp_instr;
    exp_instr = {32'h1000_0033, 32'h1000_0022, 32'h1000_0011, 32'h1000_0000};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    bus.rsp_ready = 1'b0;
    issue_req({32'h33, 32'h22, 32'h11, 32'h00}, 4'b1111);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL bp_latency got %0d want 5", lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_instr !== exp_instr ||
          bus.rsp_lane_valid !== 4'b1111 || bus.rsp_fault !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got valid=%b ready=%b instr=%h lv=%b want 1/0/%h/1111", i, bus.rsp_valid, bus.req_ready, bus.rsp_instr, bus.rsp_lane_valid, exp_instr);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    exp_count++;
    n_checks++; if (bus.fetch_count !== exp_count || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got count=%0d valid=%b want %0d/0", bus.fetch_count, bus.rsp_valid, exp_count); end
  endtask

  task automatic test_flush;
    int seen;
    // flush in IDLE blocks the accept
    @(negedge clk);
    bus.req_pc = {32'd3, 32'd2, 32'd1, 32'd0};
    bus.req_lane_en = 4'b1111;
    bus.req_valid = 1'b1;
    bus.flush = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_idle_ready got %b want 0", bus.req_ready); end
    @(negedge clk);
    n_checks++; if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL flush_idle_accept got rd_en=%b want 0", bus.mem_rd_en); end
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    // flush during the lane-2 issue cycle
    @(negedge clk);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 10'd2) begin n_fail++; $display("FAIL flush_lane2_issue got rd_en=%b addr=%0d want 1/2", bus.mem_rd_en, bus.mem_addr); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL flush_to_idle got valid=%b ready=%b rd_en=%b want 0/1/0", bus.rsp_valid, bus.req_ready, bus.mem_rd_en); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    n_checks++; if (seen !== 0 || bus.fetch_count !== exp_count) begin n_fail++; $display("FAIL flush_no_rsp got valid_cycles=%0d count=%0d want 0/%0d", seen, bus.fetch_count, exp_count); end
    // flush in RESP beats a simultaneous handshake
    issue_req({32'd23, 32'd22, 32'd21, 32'd20}, 4'b1111);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    n_checks++; if (bus.fetch_count !== exp_count || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_resp got count=%0d valid=%b want %0d/0", bus.fetch_count, bus.rsp_valid, exp_count); end
    // fresh request after the aborted ones
    issue_req({32'd13, 32'd12, 32'd11, 32'd10}, 4'b1111);
    n_checks++; if (bus.rsp_instr !== {32'h1000_000D, 32'h1000_000C, 32'h1000_000B, 32'h1000_000A} || bus.rsp_lane_valid !== 4'b1111) begin n_fail++; $display("FAIL flush_recover got %h lv=%b", bus.rsp_instr, bus.rsp_lane_valid); end
    @(negedge clk);
    exp_count++;
    n_checks++; if (bus.fetch_count !== exp_count) begin n_fail++; $display("FAIL flush_recover_count got %0d want %0d", bus.fetch_count, exp_count); end
  endtask

  task automatic test_reset_drain_and_wrap;
    int seen;
    @(negedge clk);
    bus.req_pc = {32'd43, 32'd42, 32'd41, 32'd40};
    bus.req_lane_en = 4'b1111;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.mem_addr !== '0) begin n_fail++; $display("FAIL drain_reset_ctrl got ready=%b valid=%b rd_en=%b addr=%0d", bus.req_ready, bus.rsp_valid, bus.mem_rd_en, bus.mem_addr); end
    n_checks++; if (bus.rsp_instr !== '0 || bus.rsp_lane_valid !== 4'b0 || bus.rsp_fault !== 4'b0 || bus.fetch_count !== 32'd0) begin n_fail++; $display("FAIL drain_reset_data got instr=%h lv=%b f=%b count=%0d", bus.rsp_instr, bus.rsp_lane_valid, bus.rsp_fault, bus.fetch_count); end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.rsp_instr !== '0 || bus.rsp_lane_valid !== 4'b0) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL drain_reset_quiet got %0d bad cycles want 0", seen); end
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.fetch_count_q;
    bus.rsp_ready = 1'b1;
    issue_req({32'd3, 32'd2, 32'd1, 32'd0}, 4'b0001);
    n_checks++; if (bus.rsp_instr !== {FILL, FILL, FILL, 32'h1000_0000} || bus.rsp_lane_valid !== 4'b0001) begin n_fail++; $display("FAIL wrap_instr got %h lv=%b", bus.rsp_instr, bus.rsp_lane_valid); end
    @(negedge clk);
    n_checks++; if (bus.fetch_count !== 32'd0) begin n_fail++; $display("FAIL wrap_count got %h want 00000000", bus.fetch_count); end
  endtask

  task automatic test_all_disabled;
    issue_req({32'd3, 32'd2, 32'd1, 32'd0}, 4'b0000);
    n_checks++; if (lat !== 5 || rd_log !== 4'b0000) begin n_fail++; $display("FAIL none_timing got lat=%0d reads=%b want 5/0000", lat, rd_log); end
    n_checks++; if (bus.rsp_instr !== {4{FILL}} || bus.rsp_lane_valid !== 4'b0 || bus.rsp_fault !== 4'b0) begin n_fail++; $display("FAIL none_bundle got %h lv=%b f=%b", bus.rsp_instr, bus.rsp_lane_valid, bus.rsp_fault); end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_count = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_pc = '0;
    bus.req_lane_en = '0;
    bus.flush = 1'b0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_full_bundle();
    test_sparse_enable();
    test_range_fault();
    test_backpressure();
    test_flush();
    test_reset_drain_and_wrap();
    test_all_disabled();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
